// File: rtl/digit_serial_addsub_pkg.sv
// ---------------------------------------------------------------------------
// digit_serial_addsub_pkg
//   Shared definitions for the digit-serial adder/subtractor:
//     - state_t     : controller states (IDLE / RUN / DONE)
//     - calc_ndig   : number of K-bit digits in an N-bit operand
//     - calc_cnt_w  : width of the digit counter (at least one bit)
// ---------------------------------------------------------------------------
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ndig(input int n, input int k);
    return n / k;
  endfunction

  // A single-digit configuration still needs a one-bit counter so the
  // counter declaration never collapses to zero width.
  function automatic int calc_cnt_w(input int n, input int k);
    int nd;
    nd = n / k;
    return (nd <= 1) ? 1 : $clog2(nd);
  endfunction

endpackage

// File: rtl/digit_serial_addsub_digit.sv
// ---------------------------------------------------------------------------
// addsub_digit
//   K-bit combinational ripple adder built from per-bit full-adder equations.
//   Ports:
//     a, b   in  K  digit operands
//     cin    in  1  carry into bit 0
//     s      out K  digit sum
//     cout   out 1  carry out of bit K-1
//     c_msb  out 1  carry into bit K-1 (used for signed-overflow detection)
// ---------------------------------------------------------------------------
module addsub_digit #(
  parameter int K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [K:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < K; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = w_c[K];
  assign c_msb = w_c[K-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// digit_serial_addsub
//   N-bit two's-complement adder/subtractor that processes K bits per clock,
//   least-significant digit first. One operation takes N/K RUN cycles; the
//   carry path is only K bits long.
//
//   Ports:
//     clk        in  1  rising-edge clock
//     rst        in  1  synchronous reset, active-high
//     in_valid   in  1  operand set valid
//     in_ready   out 1  high in IDLE only
//     A, B       in  N  operands
//     Op         in  1  0 = A+B, 1 = A-B
//     acc        in  1  (only with DIGIT_SERIAL_ADDSUB_ACC_EN) take A from
//                       the last completed result instead of port A
//     out_valid  out 1  result valid (DONE state)
//     out_ready  in  1  consumer accepts result
//     S          out N  sum/difference modulo 2^N
//     Cout       out 1  carry out of bit N-1 (subtract: 1 = no borrow)
//     Ovf        out 1  signed overflow
//
//   Optional feature macro: DIGIT_SERIAL_ADDSUB_ACC_EN (accumulator mode).
// ---------------------------------------------------------------------------
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Op,
`ifdef DIGIT_SERIAL_ADDSUB_ACC_EN
  input  logic         acc,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         Ovf
);

  localparam int             NDIG = calc_ndig(N, K);
  localparam int             CW   = calc_cnt_w(N, K);
  localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_s;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic [CW-1:0]   r_cnt;

  logic            w_start;
  logic            w_run;
  logic            w_last;
  logic [N-1:0]    w_a_src;
  int              w_base;
  logic [K-1:0]    w_da;
  logic [K-1:0]    w_db;
  logic [K-1:0]    w_ds;
  logic            w_dcout;
  logic            w_dcmsb;

  assign w_start = (r_state == IDLE) && in_valid;
  assign w_run   = (r_state == RUN);
  assign w_last  = w_run && (r_cnt == LAST);

  // In accumulator mode the previous result lives in r_s: it is held from
  // DONE through IDLE and is cleared by reset, so it starts from zero.
`ifdef DIGIT_SERIAL_ADDSUB_ACC_EN
  assign w_a_src = acc ? r_s : A;
`else
  assign w_a_src = A;
`endif

  // Digit selection for the current counter position.
  assign w_base = int'(r_cnt) * K;
  assign w_da   = r_a[w_base +: K];
  assign w_db   = r_b[w_base +: K];

  addsub_digit #(
    .K (K)
  ) u_digit (
    .a     (w_da),
    .b     (w_db),
    .cin   (r_carry),
    .s     (w_ds),
    .cout  (w_dcout),
    .c_msb (w_dcmsb)
  );

  // Stage: operand capture. Subtraction is folded in as A + ~B + 1, with the
  // +1 supplied through the initial carry.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_a <= w_a_src;
      r_b <= B ^ {N{Op}};
    end
  end

  // Stage: control state, carry, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_carry <= Op;
        r_cnt   <= '0;
      end else if (w_run) begin
        r_s[w_base +: K] <= w_ds;
        r_carry          <= w_dcout;
        r_cnt            <= r_cnt + 1'b1;
        if (w_last) begin
          r_cout <= w_dcout;
          r_ovf  <= w_dcmsb ^ w_dcout;
        end
      end
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign S    = r_s;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_digit_serial_addsub.sv
module tb_digit_serial_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // N=16, K=4 instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] S;
  logic        Cout;
  logic        Ovf;

  // N=8, K=8 instance
  logic        s8_in_valid = 1'b0;
  logic        s8_in_ready;
  logic [7:0]  s8_A = '0;
  logic [7:0]  s8_B = '0;
  logic        s8_Op = 1'b0;
  logic        s8_out_valid;
  logic        s8_out_ready = 1'b0;
  logic [7:0]  s8_S;
  logic        s8_Cout;
  logic        s8_Ovf;

`ifdef DIGIT_SERIAL_ADDSUB_ACC_EN
  logic        acc = 1'b0;
  logic        s8_acc = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digit_serial_addsub #(.N(16), .K(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Op        (Op),
`ifdef DIGIT_SERIAL_ADDSUB_ACC_EN
    .acc       (acc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  digit_serial_addsub #(.N(8), .K(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s8_in_valid),
    .in_ready  (s8_in_ready),
    .A         (s8_A),
    .B         (s8_B),
    .Op        (s8_Op),
`ifdef DIGIT_SERIAL_ADDSUB_ACC_EN
    .acc       (s8_acc),
`endif
    .out_valid (s8_out_valid),
    .out_ready (s8_out_ready),
    .S         (s8_S),
    .Cout      (s8_Cout),
    .Ovf       (s8_Ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake one operation on the 16-bit DUT and wait (bounded) for
  // out_valid. lat = cycles after the handshake edge, -1 on timeout.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic op, output int lat);
    A = a; B = b; Op = op; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                         input logic op, output int lat);
    s8_A = a; s8_B = b; s8_Op = op; s8_in_valid = 1'b1;
    step();
    s8_in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (s8_out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic release_out8();
    s8_out_ready = 1'b1;
    step();
    s8_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (S !== 16'h0000) begin failures++; $display("FAIL reset_S got=%h exp=0000", S); end
    checks++;
    if ({Cout, Ovf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", Cout, Ovf); end
  endtask

  task automatic test_add();
    int lat;
    run_op(16'h1234, 16'h4321, 1'b0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL add_latency got=%0d exp=4", lat); end
    checks++;
    if (S !== 16'h5555) begin failures++; $display("FAIL add_S got=%h exp=5555", S); end
    checks++;
    if ({Cout, Ovf} !== 2'b00) begin failures++; $display("FAIL add_flags got=%b%b exp=00", Cout, Ovf); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL add_in_ready_done got=%b exp=0", in_ready); end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL add_release got=%b%b exp=01", out_valid, in_ready);
    end
  endtask

  task automatic test_subtract();
    int lat;
    run_op(16'h0005, 16'h0007, 1'b1, lat);
    checks++;
    if (S !== 16'hFFFE) begin failures++; $display("FAIL sub_borrow_S got=%h exp=fffe", S); end
    checks++;
    if ({Cout, Ovf} !== 2'b00) begin failures++; $display("FAIL sub_borrow_flags got=%b%b exp=00", Cout, Ovf); end
    release_out();
    run_op(16'h0007, 16'h0005, 1'b1, lat);
    checks++;
    if (S !== 16'h0002) begin failures++; $display("FAIL sub_noborrow_S got=%h exp=0002", S); end
    checks++;
    if ({Cout, Ovf} !== 2'b10) begin failures++; $display("FAIL sub_noborrow_flags got=%b%b exp=10", Cout, Ovf); end
    release_out();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    checks++;
    if (S !== 16'h8000) begin failures++; $display("FAIL ovf_add_S got=%h exp=8000", S); end
    checks++;
    if ({Cout, Ovf} !== 2'b01) begin failures++; $display("FAIL ovf_add_flags got=%b%b exp=01", Cout, Ovf); end
    release_out();
    run_op(16'h8000, 16'h0001, 1'b1, lat);
    checks++;
    if (S !== 16'h7FFF) begin failures++; $display("FAIL ovf_sub_S got=%h exp=7fff", S); end
    checks++;
    if ({Cout, Ovf} !== 2'b11) begin failures++; $display("FAIL ovf_sub_flags got=%b%b exp=11", Cout, Ovf); end
    release_out();
  endtask

  task automatic test_back_pressure();
    int lat;
    int bad;
    run_op(16'h00FF, 16'h0001, 1'b0, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      A = 16'hAAAA; B = 16'h5555; Op = 1'b1;
      in_valid = (i % 2 == 0);
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || S !== 16'h0100 || Cout !== 1'b0 || Ovf !== 1'b0)
        bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0 S=%h", bad, S); end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready);
    end
    run_op(16'h0001, 16'h0001, 1'b0, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL bp_next_latency got=%0d exp=4", lat); end
    checks++;
    if (S !== 16'h0002) begin failures++; $display("FAIL bp_next_S got=%h exp=0002", S); end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    int seen;
    A = 16'h1111; B = 16'h1111; Op = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL midrun_ctrl got=%b%b exp=10", in_ready, out_valid);
    end
    checks++;
    if (S !== 16'h0000) begin failures++; $display("FAIL midrun_S got=%h exp=0000", S); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL midrun_no_result got=%0d exp=0", seen); end
  endtask

  task automatic test_single_digit();
    int lat;
    run_op8(8'hFF, 8'h01, 1'b0, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL k8_latency got=%0d exp=1", lat); end
    checks++;
    if (s8_S !== 8'h00) begin failures++; $display("FAIL k8_S got=%h exp=00", s8_S); end
    checks++;
    if ({s8_Cout, s8_Ovf} !== 2'b10) begin failures++; $display("FAIL k8_flags got=%b%b exp=10", s8_Cout, s8_Ovf); end
    release_out8();
`ifdef DIGIT_SERIAL_ADDSUB_ACC_EN
    s8_acc = 1'b1;
    run_op8(8'hEE, 8'h05, 1'b0, lat);
    checks++;
    if (s8_S !== 8'h05) begin failures++; $display("FAIL acc_first got=%h exp=05", s8_S); end
    release_out8();
    run_op8(8'hEE, 8'h05, 1'b0, lat);
    checks++;
    if (s8_S !== 8'h0A) begin failures++; $display("FAIL acc_second got=%h exp=0a", s8_S); end
    release_out8();
    s8_acc = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_subtract();
    test_overflow();
    test_back_pressure();
    test_reset_mid_run();
    test_single_digit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
- Multi-cycle N-bit two's-complement adder/subtractor that processes K bits per clock, least-significant digit first.
- Operands are captured through a valid/ready handshake. The result is presented through a valid/ready handshake with carry-out and signed-overflow flags.
- Used in the arithmetic datapath where wide operands would make a full ripple chain too slow. Trades latency (N/K cycles) for a short carry path (K bits).

Parameters:
- N, 16, operand and result width; must be a multiple of K.
- K, 4, digit width processed per cycle; 1 <= K <= N.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand set A/B/Op valid
- in_ready  out  1  block can accept operands
- A  in  N  operand A
- B  in  N  operand B
- Op  in  1  0 = add (A+B); 1 = subtract (A-B via B xor Op plus carry-in Op)
- out_valid  out  1  S/Cout/Ovf valid
- out_ready  in  1  consumer accepts result
- S  out  N  sum/difference, modulo 2^N
- Cout  out  1  carry out of bit N-1 (subtract: 1 = no borrow, i.e. A >= B unsigned)
- Ovf  out  1  signed overflow = carry into bit N-1 xor carry out of bit N-1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. rst dominates every other input in the same cycle.
- Reset values: in_ready=1, out_valid=0, S=0, Cout=0, Ovf=0. FSM=IDLE, digit counter=0, carry register=0.
- NDIG = N/K.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture A into an operand register, capture B^{N{Op}} into a second operand register, set carry register = Op, clear the counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, add digit[cnt] of the two operand registers plus the carry register through one K-bit ripple stage.
  - Write the K result bits into S[cnt*K +: K], update the carry register, increment cnt.
  - On the cycle with cnt = NDIG-1:
    - Cout = carry out of that stage.
    - Ovf = carry into bit K-1 of that stage xor its carry out.
    - Go to DONE.
- DONE:
  - out_valid=1; S, Cout and Ovf are held stable.
  - On out_ready: out_valid drops and the FSM returns to IDLE.
  - No new operands are accepted in DONE (in_ready=0). Throughput is one operation per NDIG+2 cycles.
- Latency: the in_valid handshake at cycle t gives out_valid=1 at cycle t+NDIG+1.
- S and the flags may change during RUN. They are meaningful only while out_valid=1.
- NDIG=1 (K=N): RUN lasts one cycle.
- Back-pressure: out_ready low holds DONE indefinitely with outputs frozen.
- Reset mid-RUN or in DONE: abandon the operation, no out_valid pulse, outputs return to reset values next cycle.
- Inputs A/B/Op are sampled only at handshake. Later changes have no effect.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDSUB_ACC_EN.
- When defined:
  - Extra input acc (1 bit).
  - If acc=1 at the input handshake, the A operand is taken from the last completed S instead of port A. This forms an accumulator; the value is 0 after reset.
  - Cout and Ovf apply to that operation.
- When undefined: port acc is absent and A is always taken from the port.

Decomposition:
- Shared package: FSM state enum (IDLE/RUN/DONE) and the NDIG/counter-width helper function.
- One sub-module: addsub_digit. It is a K-bit combinational ripple adder with inputs a, b, cin and outputs s, cout, c_msb (carry into its top bit), built from per-bit full-adder equations. The top level holds the FSM, registers and counter.

Test Plan (N=16, K=4 unless stated):
- Add: A=0x1234, B=0x4321, Op=0 -> after 5 cycles out_valid=1, S=0x5555, Cout=0, Ovf=0.
- Subtract with borrow: A=0x0005, B=0x0007, Op=1 -> S=0xFFFE, Cout=0, Ovf=0. Then A=0x0007, B=0x0005 -> S=0x0002, Cout=1.
- Signed overflow: A=0x7FFF, B=0x0001, Op=0 -> S=0x8000, Cout=0, Ovf=1. Then A=0x8000, B=0x0001, Op=1 -> S=0x7FFF, Cout=1, Ovf=1.
- Back-pressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0 throughout. in_valid pulses during this time are ignored; the next accepted operation starts only after return to IDLE.
- Reset mid-RUN: assert rst at the second RUN cycle -> next cycle in_ready=1, out_valid=0, S=0, and no result is ever emitted.
- N=8, K=8 build: A=0xFF, B=0x01, Op=0 -> out_valid at t+2, S=0x00, Cout=1, Ovf=0. With ACC_EN: acc=1 after this result, B=0x05, Op=0 -> S=0x05.
